// File: rtl/instr_mem_responder_if.sv
// ---------------------------------------------------------------------------
// instr_mem_responder_if
// Instruction-fetch bus between a core (master) and the instruction memory
// responder (slave).
//   req        master -> slave  fetch request
//   addr       master -> slave  fetch byte address
//   gnt        slave  -> master request accepted this cycle
//   rvalid     slave  -> master response valid this cycle
//   rdata      slave  -> master fetched word
//   rdata_intg slave  -> master integrity bits of rdata
//   err        slave  -> master response is an error (qualified by rvalid)
// ---------------------------------------------------------------------------
interface instr_mem_responder_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic [6:0]  rdata_intg;
    logic        err;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata,
        input  rdata_intg,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata,
        output rdata_intg,
        output err
    );
endinterface

// File: rtl/instr_mem_responder.sv
// ---------------------------------------------------------------------------
// instr_mem_responder
// Memory end of the instruction-fetch bus. Holds a word-addressed RAM that is
// preloaded through a side write port, grants fetches, and returns the word
// (with 7 integrity bits, or an error for bad addresses) a fixed LATENCY
// cycles after the grant, strictly in acceptance order.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset (clears response path only)
//   instr_bus    fetch bus, slave side (req/addr in; gnt/rvalid/rdata/intg/err out)
//   stall_i      forces the grant low (handshake stress)
//   mem_we_i     preload write enable
//   mem_waddr_i  preload word index
//   mem_wdata_i  preload data
// ---------------------------------------------------------------------------
module instr_mem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned MAX_OUT   = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    instr_mem_responder_if.slave       instr_bus,
    input  logic                       stall_i,
    input  logic                       mem_we_i,
    input  logic [$clog2(DEPTH)-1:0]   mem_waddr_i,
    input  logic [31:0]                mem_wdata_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    // One slot of the response pipeline. Empty slots carry all-zero fields so
    // the bus outputs are clean zeros whenever rvalid is low.
    typedef struct packed {
        logic        vld;
        logic        err;
        logic [6:0]  intg;
        logic [31:0] data;
    } stage_t;

    // Integrity bit i is the XOR of every data bit j with j mod 7 == i.
    function automatic logic [6:0] intg_f(input logic [31:0] d);
        logic [6:0] p;
        p = 7'h00;
        for (int i = 0; i < 7; i++) begin
            for (int j = i; j < 32; j += 7) begin
                p[i] = p[i] ^ d[j];
            end
        end
        return p;
    endfunction

    logic [31:0]   mem_q [DEPTH];
    stage_t        stage_q [LATENCY];
    stage_t        stage_d [LATENCY];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic          gnt_s;
    logic          accept_s;
    logic [31:0]   offset_s;
    logic [31:0]   idx_s;
    logic          addr_err_s;
    logic [31:0]   rd_word_s;

    // Grant, address decode, RAM read and next state of pipeline and counter.
    always_comb begin
        gnt_s      = instr_bus.req & ~stall_i & ~rst_i & (cnt_q < CW'(MAX_OUT));
        accept_s   = instr_bus.req & gnt_s;

        // Index arithmetic wraps modulo 2^32, so addresses below BASE_ADDR
        // land on huge indices and fall out of range.
        offset_s   = instr_bus.addr - BASE_ADDR;
        idx_s      = {2'b00, offset_s[31:2]};
        addr_err_s = (instr_bus.addr[1:0] != 2'b00) || (idx_s >= 32'(DEPTH));

        // Combinational read of the array sees the value before any preload
        // write on the same edge (read-before-write).
        if (addr_err_s) begin
            rd_word_s = 32'h0000_0000;
        end else begin
            rd_word_s = mem_q[idx_s[AW-1:0]];
        end

        for (int i = 0; i < int'(LATENCY); i++) begin
            stage_d[i] = '0;
        end
        if (accept_s) begin
            stage_d[0].vld  = 1'b1;
            stage_d[0].err  = addr_err_s;
            stage_d[0].data = rd_word_s;
            stage_d[0].intg = intg_f(rd_word_s);
        end else begin
            stage_d[0] = '0;
        end
        for (int i = 1; i < int'(LATENCY); i++) begin
            stage_d[i] = stage_q[i - 1];
        end

        // A request stops counting as outstanding once it moves into the
        // output slot, i.e. the cycle it is presented with rvalid. This lets
        // a new grant overlap the response cycle, so back-to-back grants are
        // sustained whenever MAX_OUT > LATENCY-1.
        cnt_d = cnt_q + CW'(accept_s) - CW'(stage_d[LATENCY-1].vld);
    end

    // Response pipeline and outstanding counter; reset drops in-flight data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                stage_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                stage_q[i] <= stage_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

    // Preload port; RAM contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_i) begin
            mem_q[mem_waddr_i] <= mem_wdata_i;
        end
    end

    assign instr_bus.gnt        = gnt_s;
    assign instr_bus.rvalid     = stage_q[LATENCY-1].vld;
    assign instr_bus.err        = stage_q[LATENCY-1].err;
    assign instr_bus.rdata      = stage_q[LATENCY-1].data;
    assign instr_bus.rdata_intg = stage_q[LATENCY-1].intg;

endmodule
